reg_file_mp_pc: RTL
===================

// Module: reg_file_mp_pc
// PURPOSE
//  Parametrised CPU register file: 2 combinational read ports and 2 write ports.
//  Top four registers are dedicated: PC, SP, LR, ST. PC has increment/load, SP has push/pop.
//  After reset, a sweep FSM zeroes the general registers, then signals ready.
//  Sits between decode (addresses) and execute/writeback (data) in the CPU core.
// PARAMETERS
//  DW       32   data width of every register
//  AW       5    register address width
//  NREGS    32   register count (<= 2**AW, >= 8); PC=NREGS-1, SP=NREGS-2, LR=NREGS-3, ST=NREGS-4
//  PC_RST   0    PC value on reset
//  SP_RST   0    SP value on reset
//  SP_STEP  1    SP decrement on push / increment on pop
// PORTS
//  clk      in   1       rising-edge clock
//  rst_n    in   1       asynchronous reset, active-low
//  ra0,ra1  in   AW      read addresses
//  rd0,rd1  out  DW      read data (combinational)
//  we       in   2       write enables, per port
//  wa0,wa1  in   AW      write addresses
//  wd0,wd1  in   DW      write data
//  pc_inc   in   1       PC <= PC+1
//  pc_ld    in   1       PC <= pc_in
//  pc_in    in   DW      PC load value
//  sp_push  in   1       SP <= SP-SP_STEP
//  sp_pop   in   1       SP <= SP+SP_STEP
//  st_we    in   1       ST <= st_in
//  st_in    in   DW      status write value
//  pcout,spout,lrout,stout  out DW  direct views of the dedicated registers
//  ready    out  1       high when the sweep is done and the file accepts updates
// BEHAVIOUR
//  Reset (rst_n=0, async): PC=PC_RST, SP=SP_RST, LR=0, ST=0, state=CLEAR, cnt=0, ready=0.
//  FSM CLEAR: each clk writes regs[cnt]=0 and increments cnt. At cnt==NREGS-5, the last
//   clear is written and state goes to RUN. ready=1 from the next cycle, i.e. NREGS-4 clocks after rst_n rises.
//  In CLEAR: we, pc_*, sp_*, st_we are ignored; rd0/rd1 read 0; pcout..stout show reset values.
//  In RUN: writes take effect at the posedge; reads are combinational from the array, with no bypass.
//  Register 0 reads 0 and writes to it are discarded (hardwired zero).
//  wa0==wa1 with both enabled: port 1 wins.
//  PC: pc_ld wins over write-port writes to PC, which win over pc_inc. Increment wraps modulo 2**DW.
//  SP: a write-port write to SP wins over push/pop. push&pop together leaves SP unchanged.
//   SP arithmetic wraps modulo 2**DW.
//  ST: st_we wins over write-port writes to ST.
//  LR is written only through the write ports.
//  Addresses >= NREGS: reads return 0, writes are discarded.
//  rst_n asserted mid-operation or mid-sweep: reset state as above, and the sweep restarts from cnt=0.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: a read whose address matches an enabled write in the same cycle
//   returns that write data combinationally (port 1 over port 0). It also forwards
//   pc_ld->pc_in and st_we->st_in for reads of PC/ST. Register 0 and CLEAR state are never bypassed.
//  Not defined: reads return the pre-edge register value; new data is visible the cycle after the write.
// TESTING
//  1. Release rst_n, NREGS=32 -> ready rises after 28 clks; rd0 of r1..r27 = 0; pcout=PC_RST.
//  2. we=2'b11, wa0=wa1=5, wd0=0xAAAA, wd1=0x5555 -> next cycle rd0(ra0=5)=0x5555.
//  3. pc_inc=1 and pc_ld=1, pc_in=0x100, PC=0x40 -> PC=0x100; then pc_inc 3 clks -> 0x103;
//     PC=0xFFFFFFFF + inc -> 0.
//  4. SP=0x10, SP_STEP=4: push -> 0x0C; push+pop -> 0x0C; write port to SP=0x80 with push -> 0x80.
//  5. Write r0=0x1234 -> rd0(ra0=0)=0. st_we with st_in=0x7 and write-port ST=0x9 -> ST=0x7.
//  6. Assert rst_n=0 mid-sweep at cnt=10 -> ready=0, cnt=0, full sweep re-runs.
//     With REGFILE_BYPASS_EN: wa0=ra0=3, wd0=0x77 -> rd0=0x77 in the same cycle.

Source files
------------

// File: rtl/reg_file_mp_pc.sv
// reg_file_mp_pc: CPU register file with 2 combinational read ports, 2 write ports
// and four dedicated top registers (PC, SP, LR, ST). After reset a sweep FSM zeroes
// the general registers and then raises ready.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the
// read ports (port 1 over port 0, pc_ld/st_we over the write ports for PC/ST).
module reg_file_mp_pc #(
  parameter int              DW      = 32,
  parameter int              AW      = 5,
  parameter int              NREGS   = 32,
  parameter logic [DW-1:0]   PC_RST  = '0,
  parameter logic [DW-1:0]   SP_RST  = '0,
  parameter int              SP_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  input  logic [1:0]    we,
  input  logic [AW-1:0] wa0,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  input  logic          pc_inc,
  input  logic          pc_ld,
  input  logic [DW-1:0] pc_in,
  input  logic          sp_push,
  input  logic          sp_pop,
  input  logic          st_we,
  input  logic [DW-1:0] st_in,
  output logic [DW-1:0] pcout,
  output logic [DW-1:0] spout,
  output logic [DW-1:0] lrout,
  output logic [DW-1:0] stout,
  output logic          ready
);

  // Dedicated register addresses and the number of general (swept) registers.
  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);
  localparam logic [AW-1:0] SP_A = AW'(NREGS - 2);
  localparam logic [AW-1:0] LR_A = AW'(NREGS - 3);
  localparam logic [AW-1:0] ST_A = AW'(NREGS - 4);
  localparam int            NGEN = NREGS - 4;
  localparam logic [AW-1:0] LAST = AW'(NGEN - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [DW-1:0] r_pc, r_sp, r_lr, r_st;
  // Register 0 is hardwired to zero, so no storage exists for it.
  logic [DW-1:0] r_gen [1:NGEN-1];

  logic w_run;
  logic w_wr0, w_wr1;
  assign w_run = (r_state == S_RUN);
  assign w_wr0 = w_run & we[0];
  assign w_wr1 = w_run & we[1];

  // Sweep FSM state and clear counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep FSM next state: walk cnt over the general registers, then settle in RUN.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == S_CLEAR) begin
      if (r_cnt == LAST) begin
        w_state_nxt = S_RUN;
      end else begin
        w_cnt_nxt = r_cnt + AW'(1);
      end
    end
  end

  // General registers: zeroed by the sweep, then written by the ports (port 1 wins).
  // NOTE: the array has no reset branch; the post-reset sweep clears it instead,
  // which keeps it mappable to plain flops/RAM without a reset net.
  always_ff @(posedge clk) begin
    for (int i = 1; i < NGEN; i++) begin
      if (r_state == S_CLEAR) begin
        if (r_cnt == AW'(i)) r_gen[i] <= '0;
      end else if (we[1] && wa1 == AW'(i)) begin
        r_gen[i] <= wd1;
      end else if (we[0] && wa0 == AW'(i)) begin
        r_gen[i] <= wd0;
      end
    end
  end

  // Dedicated registers with their priority rules; frozen while the sweep runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_RST;
      r_sp <= SP_RST;
      r_lr <= '0;
      r_st <= '0;
    end else if (w_run) begin
      if (pc_ld)                       r_pc <= pc_in;
      else if (we[1] && wa1 == PC_A)   r_pc <= wd1;
      else if (we[0] && wa0 == PC_A)   r_pc <= wd0;
      else if (pc_inc)                 r_pc <= r_pc + DW'(1);

      if (we[1] && wa1 == SP_A)        r_sp <= wd1;
      else if (we[0] && wa0 == SP_A)   r_sp <= wd0;
      else if (sp_push && !sp_pop)     r_sp <= r_sp - DW'(SP_STEP);
      else if (sp_pop && !sp_push)     r_sp <= r_sp + DW'(SP_STEP);

      if (we[1] && wa1 == LR_A)        r_lr <= wd1;
      else if (we[0] && wa0 == LR_A)   r_lr <= wd0;

      if (st_we)                       r_st <= st_in;
      else if (we[1] && wa1 == ST_A)   r_st <= wd1;
      else if (we[0] && wa0 == ST_A)   r_st <= wd0;
    end
  end

  // Read mux for one port; r0 and out-of-range addresses fall through to zero.
  function automatic logic [DW-1:0] f_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 1; i < NGEN; i++) begin
      if (a == AW'(i)) v = r_gen[i];
    end
    if (a == ST_A) v = r_st;
    if (a == LR_A) v = r_lr;
    if (a == SP_A) v = r_sp;
    if (a == PC_A) v = r_pc;
`ifdef REGFILE_BYPASS_EN
    if (a != '0 && a <= PC_A) begin
      if (w_wr0 && wa0 == a) v = wd0;
      if (w_wr1 && wa1 == a) v = wd1;
      if (w_run && pc_ld && a == PC_A) v = pc_in;
      if (w_run && st_we && a == ST_A) v = st_in;
    end
`else
    // Same-cycle writes are not forwarded; these enables only matter with bypass.
    if (w_wr0 && w_wr1) v = v;
`endif
    return v;
  endfunction

  // Combinational read ports; forced to zero while the sweep is running.
  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (w_run) begin
      rd0 = f_read(ra0);
      rd1 = f_read(ra1);
    end
  end

  assign pcout = r_pc;
  assign spout = r_sp;
  assign lrout = r_lr;
  assign stout = r_st;
  assign ready = w_run;

endmodule
